rgb_pwm_ctrl: RTL and testbench



---
 rtl/rgb_pwm_pkg.sv | 18 +
 rtl/rgb_pwm_chan.sv | 40 ++++
 rtl/rgb_pwm_ctrl.sv | 143 ++++++++++++++
 tb/tb_rgb_pwm_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared types and defaults for the RGB LED driver sequencer and PWM source.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_RUN
    } state_t;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    localparam int DEF_SETTLE_CYCLES = 1200;
    localparam int DEF_PRESCALE      = 47;
    localparam int DEF_PWM_BITS      = 8;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: shadow duty, active duty and the registered duty comparator.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [PWM_BITS-1:0] wr_data,
    input  logic                load,
    input  logic                run_next,
    input  logic [PWM_BITS-1:0] cnt_next,
    output logic                pwm
);

    logic [PWM_BITS-1:0] shadow;
    logic [PWM_BITS-1:0] active;
    logic [PWM_BITS-1:0] active_next;

    // A write on a load edge lands in shadow only; active takes the old shadow.
    always_comb begin
        active_next = load ? shadow : active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= wr_data;
            end
            active <= active_next;
            pwm    <= run_next && (cnt_next < active_next);
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Enable sequencing (CURREN, settle, RGBLEDEN) and three-channel PWM for the
// iCE40UP RGB LED driver primitive.
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int PRESCALE      = DEF_PRESCALE,
    parameter int PWM_BITS      = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_valid,
    input  logic [1:0]          wr_sel,
    input  logic [PWM_BITS-1:0] wr_data,
    output logic                wr_ready,
    output logic                curren,
    output logic                rgbleden,
    output logic [2:0]          pwm,
    output logic                running,
    output logic                period_start
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    state_t              state;
    state_t              state_next;
    logic [SW-1:0]       settle;
    logic [PW-1:0]       presc;
    logic [PW-1:0]       presc_next;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] cnt_next;
    logic                tick;
    logic                wrap;
    logic                run_entry;
    logic                load;
    logic                wr_fire;
    logic                curren_next;
    logic                run_next;

    // State register; outputs are registered from the next-state decode so
    // they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_OFF;
            settle       <= '0;
            presc        <= '0;
            cnt          <= '0;
            wr_ready     <= 1'b0;
            curren       <= 1'b0;
            rgbleden     <= 1'b0;
            running      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != ST_SETTLE) begin
                settle <= '0;
            end else if (state != ST_SETTLE) begin
                settle <= SW'(SETTLE_CYCLES - 1);
            end else begin
                settle <= settle - 1'b1;
            end
            presc        <= presc_next;
            cnt          <= cnt_next;
            wr_ready     <= 1'b1;
            curren       <= curren_next;
            rgbleden     <= run_next;
            running      <= run_next;
            period_start <= load;
        end
    end

    // Next state plus the prescaler / PWM counter advance.
    always_comb begin
        state_next = state;
        case (state)
            ST_OFF:    if (en) state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (!en) begin
                    state_next = ST_OFF;
                end else if (settle == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:    if (!en) state_next = ST_OFF;
            default:   state_next = ST_OFF;
        endcase

        tick       = (presc == PW'(PRESCALE));
        run_entry  = (state_next == ST_RUN) && (state != ST_RUN);
        presc_next = '0;
        cnt_next   = '0;
        wrap       = 1'b0;
        if ((state_next == ST_RUN) && !run_entry) begin
            presc_next = tick ? '0 : presc + 1'b1;
            cnt_next   = tick ? cnt + 1'b1 : cnt;
            wrap       = tick && (cnt == CNT_MAX);
        end
        load = run_entry || wrap;
    end

    always_comb begin
        curren_next = (state_next != ST_OFF);
        run_next    = (state_next == ST_RUN);
        wr_fire     = wr_valid && wr_ready;
    end

    rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_r (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_fire && (wr_sel == 2'(CH_R))),
        .wr_data  (wr_data),
        .load     (load),
        .run_next (run_next),
        .cnt_next (cnt_next),
        .pwm      (pwm[CH_R])
    );

    rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_g (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_fire && (wr_sel == 2'(CH_G))),
        .wr_data  (wr_data),
        .load     (load),
        .run_next (run_next),
        .cnt_next (cnt_next),
        .pwm      (pwm[CH_G])
    );

    rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_fire && (wr_sel == 2'(CH_B))),
        .wr_data  (wr_data),
        .load     (load),
        .run_next (run_next),
        .cnt_next (cnt_next),
        .pwm      (pwm[CH_B])
    );

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl: directed sequence plus randomized traffic
// against a cycle-count reference model.
module tb_rgb_pwm_ctrl;

    localparam int S   = 10;
    localparam int P   = 0;
    localparam int B   = 8;
    localparam int PER = 1 << B;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         wr_valid = 1'b0;
    logic [1:0]   wr_sel = 2'd0;
    logic [B-1:0] wr_data = '0;
    logic         wr_ready;
    logic         curren;
    logic         rgbleden;
    logic [2:0]   pwm;
    logic         running;
    logic         period_start;
    logic [7:0]   out_vec;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rgb_pwm_ctrl #(.SETTLE_CYCLES(S), .PRESCALE(P), .PWM_BITS(B)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .wr_valid     (wr_valid),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .curren       (curren),
        .rgbleden     (rgbleden),
        .pwm          (pwm),
        .running      (running),
        .period_start (period_start)
    );

    assign out_vec = {wr_ready, curren, rgbleden, running, period_start, pwm};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=off 1=settle 2=run, time since entry, duties.
    int  m_phase = 0;
    int  m_el = 0;
    int  m_t = 0;
    int  m_shadow[3] = '{0, 0, 0};
    int  m_active[3] = '{0, 0, 0};
    bit  m_ready = 1'b0;
    bit  m_valid = 1'b0;
    bit  m_load = 1'b0;

    always @(posedge clk) begin
        bit ready_old;
        ready_old = m_ready;
        m_load = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_el = 0;
            m_t = 0;
            for (int i = 0; i < 3; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_ready = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (!en) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                m_phase = 1;
                m_el = 0;
            end else if (m_phase == 1) begin
                m_el++;
                if (m_el == S) begin
                    m_phase = 2;
                    m_t = 0;
                    m_load = 1'b1;
                end
            end else begin
                m_t++;
                if (m_t % (PER * (P + 1)) == 0) m_load = 1'b1;
            end
            if (m_load) begin
                for (int i = 0; i < 3; i++) m_active[i] = m_shadow[i];
            end
            if (wr_valid && ready_old && wr_sel != 2'd3) m_shadow[wr_sel] = int'(wr_data);
            m_ready = 1'b1;
        end
    end

    function automatic logic [7:0] expected();
        logic [2:0] p;
        int c;
        c = (m_t / (P + 1)) % PER;
        for (int i = 0; i < 3; i++) p[i] = (m_phase == 2) && (c < m_active[i]);
        return {m_ready, m_phase != 0, m_phase == 2, m_phase == 2, m_load, p};
    endfunction

    always @(negedge clk) begin
        if (m_valid) check("outputs_vs_model", int'(out_vec), int'(expected()));
    end

    task automatic do_write(input int sel, input int data);
        wr_valid = 1'b1;
        wr_sel = 2'(sel);
        wr_data = B'(data);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Runs one PWM period starting at a period boundary, counting high cycles.
    task automatic run_period(input int wr_at, input int sel, input int data,
                              output int c0, output int c1, output int c2);
        check("period_start_at_boundary", int'(period_start), 1);
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 0; k < PER; k++) begin
            c0 += int'(pwm[0]);
            c1 += int'(pwm[1]);
            c2 += int'(pwm[2]);
            if (k == wr_at) begin
                wr_valid = 1'b1;
                wr_sel = 2'(sel);
                wr_data = B'(data);
            end
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic period_expect(input string name, input int wr_at, input int sel,
                                 input int data, input int e0, input int e1, input int e2);
        int c0, c1, c2;
        run_period(wr_at, sel, data, c0, c1, c2);
        check({name, "_ch0"}, c0, e0);
        check({name, "_ch1"}, c1, e1);
        check({name, "_ch2"}, c2, e2);
    endtask

    task automatic settle_to_run(input string name);
        en = 1'b1;
        @(negedge clk);
        check({name, "_curren_edge0"}, int'(curren), 1);
        check({name, "_rgbleden_edge0"}, int'(rgbleden), 0);
        repeat (S - 1) @(negedge clk);
        check({name, "_rgbleden_before"}, int'(rgbleden), 0);
        @(negedge clk);
        check({name, "_rgbleden_entry"}, int'(rgbleden), 1);
        check({name, "_running_entry"}, int'(running), 1);
        check({name, "_period_start_entry"}, int'(period_start), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hold;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'(out_vec), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("wr_ready_after_reset", int'(wr_ready), 1);
        check("off_curren", int'(curren), 0);

        do_write(0, 64);
        do_write(1, 128);
        do_write(2, 255);
        settle_to_run("enable");

        period_expect("first_period", -1, 0, 0, 64, 128, 255);
        period_expect("mid_write_period", 100, 0, 10, 64, 128, 255);
        period_expect("after_mid_write", -1, 0, 0, 10, 128, 255);
        period_expect("wrap_write_period", PER - 1, 0, 30, 10, 128, 255);
        period_expect("wrap_write_delayed", -1, 0, 0, 10, 128, 255);
        period_expect("wrap_write_applied", 50, 1, 0, 30, 128, 255);
        period_expect("duty0_a_sel3", 20, 3, 200, 30, 0, 255);
        period_expect("duty0_b", -1, 0, 0, 30, 0, 255);
        period_expect("duty0_c", -1, 0, 0, 30, 0, 255);

        en = 1'b0;
        @(negedge clk);
        check("disable_run_pwm", int'(pwm), 0);
        check("disable_run_rgbleden", int'(rgbleden), 0);
        check("disable_run_curren", int'(curren), 0);

        en = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("disable_settle_curren", int'(curren), 0);
        settle_to_run("reenable");
        period_expect("reenable_period", -1, 0, 0, 30, 0, 255);

        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_run_outputs", int'(out_vec), 0);
        rst = 1'b0;
        settle_to_run("after_reset");
        period_expect("after_reset_period", -1, 0, 0, 0, 0, 0);

        hold = 0;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                en = ~en;
                hold = en ? int'($urandom_range(20, 700)) : int'($urandom_range(1, 15));
            end
            hold--;
            wr_valid = ($urandom_range(0, 99) < 20);
            wr_sel = 2'($urandom_range(0, 3));
            wr_data = B'($urandom);
            rst = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        wr_valid = 1'b0;
        en = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
